// File: rtl/banked_sync_ram.sv
// Banked single-port synchronous RAM with a self-clearing INIT phase.
// Each bank is cleared one row per cycle in parallel before requests are accepted.
module banked_sync_ram #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int BANK_BITS  = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cs,
    input  logic                        we,
    input  logic [DATA_WIDTH/8-1:0]     be,
    input  logic [ADDR_WIDTH-1:0]       addr,
    input  logic [DATA_WIDTH-1:0]       wdata,
    output logic                        req_ready,
    output logic [DATA_WIDTH-1:0]       rdata,
    output logic                        rdata_valid,
    output logic                        init_done,
    output logic [2**BANK_BITS-1:0]     bank_hit
);

    localparam int ROW_W = ADDR_WIDTH - BANK_BITS;
    localparam int NB    = 2 ** BANK_BITS;
    localparam int ROWS  = 2 ** ROW_W;
    localparam int NBYTE = DATA_WIDTH / 8;

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [ROW_W-1:0]       r_row;
    logic [DATA_WIDTH-1:0]  r_rdata;
    logic                   r_valid;
    logic [NB-1:0]          r_bank_hit;

    logic [BANK_BITS-1:0]   w_bank;
    logic [ROW_W-1:0]       w_row_addr;
    logic                   w_run;
    logic                   w_acc;
    logic                   w_rd_acc;
    logic [ROW_W-1:0]       w_mem_row;
    logic [DATA_WIDTH-1:0]  w_mem_wd;
    logic [NBYTE-1:0]       w_mem_be;
    logic [NB-1:0]          w_bank_we;
    logic [DATA_WIDTH-1:0]  w_rd_word [NB];

    assign w_bank     = addr[ADDR_WIDTH-1 -: BANK_BITS];
    assign w_row_addr = addr[ROW_W-1:0];
    assign w_run      = (r_state == S_RUN);
    assign w_acc      = cs & w_run;
    assign w_rd_acc   = w_acc & ~we;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_INIT;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_INIT: if (&r_row) w_next = S_RUN;
            S_RUN:  w_next = S_RUN;
        endcase
    end

    always_comb begin
        req_ready = w_run;
        init_done = w_run;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)               r_row <= '0;
        else if (r_state == S_INIT) r_row <= r_row + 1'b1;
    end

    // INIT drives a zero write into the same row of every bank at once
    assign w_mem_row = w_run ? w_row_addr : r_row;
    assign w_mem_wd  = w_run ? wdata : '0;
    assign w_mem_be  = w_run ? be : '1;

    for (genvar b = 0; b < NB; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] r_mem [ROWS];

        assign w_bank_we[b] = rst_n &
            (~w_run | (w_acc & we & (w_bank == BANK_BITS'(b))));

        always_ff @(posedge clk) begin
            if (w_bank_we[b]) begin
                for (int k = 0; k < NBYTE; k++) begin
                    if (w_mem_be[k])
                        r_mem[w_mem_row][k*8 +: 8] <= w_mem_wd[k*8 +: 8];
                end
            end
        end

        assign w_rd_word[b] = r_mem[w_row_addr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_rd_acc;
            if (w_rd_acc) r_rdata <= w_rd_word[w_bank];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)     r_bank_hit <= '0;
        else if (w_acc) r_bank_hit <= NB'(1) << w_bank;
    end

    assign rdata       = r_rdata;
    assign rdata_valid = r_valid;
    assign bank_hit    = r_bank_hit;

endmodule

// File: tb/tb_banked_sync_ram.sv
// Directed bench for banked_sync_ram: stimulus pushes expected reads into a
// scoreboard, a negedge monitor pops and checks them as rdata_valid appears.
module tb_banked_sync_ram;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  be = 2'b00;
    logic [11:0] addr = '0;
    logic [15:0] wdata = '0;
    logic        req_ready;
    logic [15:0] rdata;
    logic        rdata_valid;
    logic        init_done;
    logic [3:0]  bank_hit;

    banked_sync_ram #(
        .ADDR_WIDTH(12),
        .DATA_WIDTH(16),
        .BANK_BITS (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs         (cs),
        .we         (we),
        .be         (be),
        .addr       (addr),
        .wdata      (wdata),
        .req_ready  (req_ready),
        .rdata      (rdata),
        .rdata_valid(rdata_valid),
        .init_done  (init_done),
        .bank_hit   (bank_hit)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [15:0] data;
        int          due;
        logic [11:0] a;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rdata_valid === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_rdata_valid: got rdata=%h cyc=%0d expected no valid",
                         rdata, cyc);
            end else begin
                e = sb.pop_front();
                if (rdata !== e.data || cyc != e.due) begin
                    miscompares++;
                    $display("FAIL read_%h: got %h at cyc %0d expected %h at cyc %0d",
                             e.a, rdata, cyc, e.data, e.due);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic w, input logic [1:0] b,
                       input logic [11:0] a, input logic [15:0] d,
                       input logic [3:0] hit);
        exp_t e;
        cs = 1'b1; we = w; be = b; addr = a; wdata = d;
        if (!w) begin
            e.data = d; e.due = cyc + 1; e.a = a;
            sb.push_back(e);
        end
        tick();
        chk("bank_hit", 32'(bank_hit), 32'(hit));
    endtask

    task automatic idle(input int n);
        cs = 1'b0; we = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drain();
        int n = 0;
        cs = 1'b0;
        while (sb.size() != 0 && n < 10) begin
            tick();
            n++;
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending reads expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int bad;
        int n;

        // Reset values
        repeat (3) tick();
        chk("rst_init_done", 32'(init_done), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rdata_valid", 32'(rdata_valid), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_bank_hit", 32'(bank_hit), 0);

        // INIT: 1024 cycles, requests offered throughout must be dropped
        rst_n = 1'b1;
        cs = 1'b1; be = 2'b11; addr = 12'h000; wdata = 16'hFFFF; we = 1'b1;
        bad = 0;
        repeat (1023) begin
            tick();
            if (init_done !== 1'b0 || req_ready !== 1'b0) bad++;
            we = ~we;
        end
        chk("init_hold_low", 32'(bad), 0);
        cs = 1'b0; we = 1'b0;
        tick();
        chk("init_done_1024", 32'(init_done), 1);
        chk("req_ready_1024", 32'(req_ready), 1);
        chk("bank_hit_after_init", 32'(bank_hit), 0);

        // Cleared memory at bank boundaries
        req(1'b0, 2'b00, 12'h000, 16'h0000, 4'b0001);
        req(1'b0, 2'b00, 12'h3FF, 16'h0000, 4'b0001);
        req(1'b0, 2'b00, 12'h400, 16'h0000, 4'b0010);
        req(1'b0, 2'b00, 12'hFFF, 16'h0000, 4'b1000);
        drain();

        // First/last rows across banks
        req(1'b1, 2'b11, 12'h3FF, 16'h1234, 4'b0001);
        req(1'b1, 2'b11, 12'h400, 16'h1234, 4'b0010);
        req(1'b1, 2'b11, 12'h7FF, 16'h1234, 4'b0010);
        req(1'b1, 2'b11, 12'hC00, 16'h1234, 4'b1000);
        idle(1);
        chk("write_no_valid", 32'(rdata_valid), 0);
        req(1'b0, 2'b00, 12'h3FF, 16'h1234, 4'b0001);
        req(1'b0, 2'b00, 12'h400, 16'h1234, 4'b0010);
        req(1'b0, 2'b00, 12'h7FF, 16'h1234, 4'b0010);
        req(1'b0, 2'b00, 12'hC00, 16'h1234, 4'b1000);
        req(1'b0, 2'b00, 12'h3FE, 16'h0000, 4'b0001);
        req(1'b0, 2'b00, 12'h401, 16'h0000, 4'b0010);
        drain();

        // Byte enables
        req(1'b1, 2'b11, 12'h010, 16'hAAAA, 4'b0001);
        req(1'b1, 2'b01, 12'h010, 16'h5555, 4'b0001);
        req(1'b0, 2'b00, 12'h010, 16'hAA55, 4'b0001);
        drain();

        // Read immediately after write to same address
        req(1'b1, 2'b11, 12'h800, 16'hBEEF, 4'b0100);
        req(1'b0, 2'b00, 12'h800, 16'hBEEF, 4'b0100);
        drain();

        // Back-to-back reads come back in order with no bubbles
        req(1'b1, 2'b11, 12'h000, 16'h1111, 4'b0001);
        req(1'b1, 2'b11, 12'h001, 16'h2222, 4'b0001);
        req(1'b1, 2'b11, 12'h002, 16'h3333, 4'b0001);
        req(1'b1, 2'b11, 12'h003, 16'h4444, 4'b0001);
        req(1'b0, 2'b00, 12'h000, 16'h1111, 4'b0001);
        req(1'b0, 2'b00, 12'h001, 16'h2222, 4'b0001);
        req(1'b0, 2'b00, 12'h002, 16'h3333, 4'b0001);
        req(1'b0, 2'b00, 12'h003, 16'h4444, 4'b0001);
        drain();

        // cs=0: no bank_hit change, rdata holds
        addr = 12'hC00; we = 1'b0;
        idle(3);
        chk("idle_bank_hit_hold", 32'(bank_hit), 32'(4'b0001));
        chk("idle_rdata_hold", 32'(rdata), 32'(16'h4444));

        // Reset at the edge that would capture a read suppresses it
        cs = 1'b1; we = 1'b0; addr = 12'h800; rst_n = 1'b0;
        tick();
        cs = 1'b0;
        chk("rst_read_valid", 32'(rdata_valid), 0);
        chk("rst_read_rdata", 32'(rdata), 0);
        chk("rst_read_bank_hit", 32'(bank_hit), 0);
        chk("rst_read_ready", 32'(req_ready), 0);

        // Reset mid-INIT restarts the clear
        rst_n = 1'b1;
        repeat (500) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n = 0;
        while (init_done !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        chk("init_restart_cycles", 32'(n), 1024);

        // All memory is zero again
        req(1'b0, 2'b00, 12'h3FF, 16'h0000, 4'b0001);
        req(1'b0, 2'b00, 12'h800, 16'h0000, 4'b0100);
        req(1'b0, 2'b00, 12'h010, 16'h0000, 4'b0001);
        req(1'b0, 2'b00, 12'hC00, 16'h0000, 4'b1000);
        drain();
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/banked_sync_ram.md
BANKED_SYNC_RAM -- requirements
Module: banked_sync_ram

Interface
REQ-001 The block SHALL have the following parameters:
- ADDR_WIDTH, default 12: word address width.
- DATA_WIDTH, default 16: word width; a multiple of 8.
- BANK_BITS, default 2: number of address MSBs used as bank select. Bank count = 2^BANK_BITS.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset.
REQ-003 The block SHALL have the following ports:
- clk, in, 1: rising-edge clock.
- rst_n, in, 1: synchronous active-low reset.
- cs, in, 1: request valid (chip select).
- we, in, 1: 1 = write, 0 = read.
- be, in, DATA_WIDTH/8: byte enables for writes; ignored for reads.
- addr, in, ADDR_WIDTH: word address.
- wdata, in, DATA_WIDTH: write data.
- req_ready, out, 1: request is accepted when cs and req_ready are both 1.
- rdata, out, DATA_WIDTH: registered read data.
- rdata_valid, out, 1: rdata carries new read data this cycle.
- init_done, out, 1: memory clear complete.
- bank_hit, out, 2^BANK_BITS: one-hot bank of the last accepted request.

Function
REQ-004 Storage SHALL be 2^BANK_BITS banks of 2^(ADDR_WIDTH-BANK_BITS) words each; bank index = addr[ADDR_WIDTH-1 -: BANK_BITS], row = remaining LSBs.
REQ-005 The FSM SHALL have states INIT and RUN; reset enters INIT.
REQ-006 In INIT:
- a row counter starting at 0 writes zero to that row in every bank in the same cycle;
- the counter increments by 1 per cycle.
REQ-007 INIT SHALL move to RUN in the cycle after the row counter writes row 2^(ADDR_WIDTH-BANK_BITS)-1; INIT therefore lasts exactly 2^(ADDR_WIDTH-BANK_BITS) cycles.
REQ-008 req_ready SHALL be 0 in INIT and 1 in RUN; requests presented during INIT SHALL be dropped with no memory or output effect.
REQ-009 init_done SHALL be 0 in INIT and 1 in RUN.
REQ-010 An accepted write SHALL update, at that clock edge, only the bytes k of the addressed word for which be[k]=1; other bytes and other banks are unchanged.
REQ-011 An accepted write SHALL NOT assert rdata_valid.
REQ-012 An accepted read SHALL load rdata and pulse rdata_valid high for exactly one cycle, on the edge following acceptance (latency 1).
REQ-013 Back-to-back reads SHALL give one rdata_valid per read, in request order, with no bubbles.
REQ-014 A read accepted in the cycle after a write to the same address SHALL return the newly written data.
REQ-015 rdata SHALL hold its last value when rdata_valid=0.
REQ-016 bank_hit SHALL update on every accepted request to the one-hot decoded bank, and hold otherwise.
REQ-017 Address arithmetic SHALL be unsigned. Every address in 0..2^ADDR_WIDTH-1 is valid, including the first and last row of each bank; there is no wrap or aliasing between banks.
REQ-018 With cs=0, the block SHALL cause no memory change, no rdata_valid, and no bank_hit change.

Reset
REQ-019 While rst_n=0 at a clock edge, the block SHALL set:
- state = INIT, row counter = 0;
- req_ready = 0, init_done = 0, rdata_valid = 0;
- rdata = 0, bank_hit = 0.
REQ-020 Reset asserted mid-INIT SHALL restart the clear from row 0. Reset asserted in the cycle after a read is accepted SHALL suppress that read's rdata_valid.
REQ-021 Memory contents after any reset SHALL be all-zero once init_done=1.

Verification
REQ-022 With the default parameters, the bench SHALL cover these directed scenarios:
- Release rst_n, hold cs=0 -> init_done=0 and req_ready=0 for 1024 cycles, then init_done=1 and req_ready=1; a read of 0x000, 0x3FF, 0x400 and 0xFFF each returns 0x0000.
- Write 0x1234 with be=2'b11 to 0x3FF, 0x400, 0x7FF, 0xC00 (first and last rows across banks), then read all four -> each returns 0x1234 one cycle after its read; bank_hit = 0001, 0010, 0010, 1000 respectively; neighbours 0x3FE and 0x401 return 0x0000.
- Write 0xAAAA with be=11 to 0x010, then write 0x5555 with be=01, then read 0x010 -> 0xAA55.
- Write 0xBEEF to 0x800, immediately followed by a read of 0x800 -> rdata=0xBEEF with rdata_valid high exactly one cycle later.
- Four back-to-back reads of 0x000..0x003 -> four consecutive rdata_valid pulses in address order; a cs=1 request during INIT -> no effect.
- Assert rst_n=0 for one cycle at INIT cycle 500 -> init_done rises 1024 cycles after release; assert rst_n=0 the cycle after a read -> no rdata_valid, rdata=0.
